// File: rtl/fsm_q3c_pkg.sv
// Shared types and combinational helpers for the q3c Moore machine.
// Illegal codes 101..111 are representable in state_t so loads can inject them.
package fsm_q3c_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  function automatic state_t q3c_next(input state_t s, input logic x);
    case (s)
      S0:      return x ? S1 : S0;
      S1:      return x ? S4 : S1;
      S2:      return x ? S1 : S2;
      S3:      return x ? S2 : S1;
      S4:      return x ? S4 : S3;
      default: return S0;
    endcase
  endfunction

  function automatic logic q3c_z(input state_t s);
    return (s == S3) || (s == S4);
  endfunction

  function automatic logic q3c_legal(input state_t s);
    return s inside {S0, S1, S2, S3, S4};
  endfunction

endpackage

// File: rtl/fsm_q3c_chan.sv
// One q3c channel: state register, sticky illegal-state flag and
// saturating counter of z rising edges.
module fsm_q3c_chan
  import fsm_q3c_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             x,
  input  logic             ld,
  input  logic [2:0]       ld_state,
  input  logic             clr,
  output logic [2:0]       state_o,
  output logic             z,
  output logic [CNT_W-1:0] z_cnt,
  output logic             err
);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load beats stepping; clear beats both the counter increment and err set.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    if (ld) begin
      state_d = state_t'(ld_state);
    end else if (en) begin
      state_d = q3c_next(state_q, x);
      if (!q3c_legal(state_q)) err_d = 1'b1;
    end
    rise = q3c_z(state_d) && !q3c_z(state_q);
    if (rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  assign state_o = state_q;
  assign z       = q3c_z(state_q);
  assign z_cnt   = cnt_q;
  assign err     = err_q;

endmodule

// File: rtl/fsm_q3c_bank.sv
// Bank of independent q3c channels with load decode and flat output packing.
// Out-of-range load channel numbers match no channel and are dropped.
module fsm_q3c_bank
  import fsm_q3c_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       x,
  input  logic                    ld_valid,
  input  logic [CH_W-1:0]         ld_ch,
  input  logic [2:0]              ld_state,
  input  logic                    clr,
  output logic [3*NUM_CH-1:0]     state_o,
  output logic [NUM_CH-1:0]       z,
  output logic [CNT_W*NUM_CH-1:0] z_cnt,
  output logic [NUM_CH-1:0]       err
);

  logic [NUM_CH-1:0] ld_hit;

  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ld_hit[i] = ld_valid && (int'(ld_ch) == i);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fsm_q3c_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .aresetn (aresetn),
      .en      (en[i]),
      .x       (x[i]),
      .ld      (ld_hit[i]),
      .ld_state(ld_state),
      .clr     (clr),
      .state_o (state_o[3*i +: 3]),
      .z       (z[i]),
      .z_cnt   (z_cnt[CNT_W*i +: CNT_W]),
      .err     (err[i])
    );
  end

endmodule

// File: tb/tb_fsm_q3c_bank.sv
// Scoreboard bench for fsm_q3c_bank: a wide-counter and a 2-bit-counter
// instance share stimulus; a table model predicts each edge's results.
module tb_fsm_q3c_bank;

  localparam int NCH  = 6;
  localparam int CH_W = 3;

  typedef struct {
    string            tag;
    logic [3*NCH-1:0] state;
    logic [NCH-1:0]   z;
    logic [8*NCH-1:0] cnt;
    logic [2*NCH-1:0] cnt_sat;
    logic [NCH-1:0]   err;
  } exp_t;

  logic             clk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic [NCH-1:0]   x = '0;
  logic             ld_valid = 1'b0;
  logic [CH_W-1:0]  ld_ch = '0;
  logic [2:0]       ld_state = '0;
  logic             clr = 1'b0;

  logic [3*NCH-1:0] state_o, state_o_s;
  logic [NCH-1:0]   z, z_s;
  logic [8*NCH-1:0] z_cnt;
  logic [2*NCH-1:0] z_cnt_s;
  logic [NCH-1:0]   err, err_s;

  logic [2:0] m_state [NCH];
  logic       m_err   [NCH];
  int         m_cnt   [NCH];
  int         m_cnt_s [NCH];
  exp_t       sb_q [$];

  int checks = 0;
  int errors = 0;

  fsm_q3c_bank #(.NUM_CH(NCH), .CNT_W(8)) dut (
    .clk(clk), .aresetn(aresetn), .en(en), .x(x), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_state(ld_state), .clr(clr),
    .state_o(state_o), .z(z), .z_cnt(z_cnt), .err(err)
  );

  fsm_q3c_bank #(.NUM_CH(NCH), .CNT_W(2)) dut_sat (
    .clk(clk), .aresetn(aresetn), .en(en), .x(x), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_state(ld_state), .clr(clr),
    .state_o(state_o_s), .z(z_s), .z_cnt(z_cnt_s), .err(err_s)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_next(input logic [2:0] s, input logic xi);
    case (s)
      3'b000:  return xi ? 3'b001 : 3'b000;
      3'b001:  return xi ? 3'b100 : 3'b001;
      3'b010:  return xi ? 3'b001 : 3'b010;
      3'b011:  return xi ? 3'b010 : 3'b001;
      3'b100:  return xi ? 3'b100 : 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic ref_z(input logic [2:0] s);
    return (s == 3'b011) || (s == 3'b100);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_state[i] = 3'b000;
      m_err[i]   = 1'b0;
      m_cnt[i]   = 0;
      m_cnt_s[i] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] en_v, input logic [NCH-1:0] x_v,
                               input logic lv, input logic [CH_W-1:0] lc,
                               input logic [2:0] ls, input logic cl, input string tag);
    exp_t e;
    logic [2:0] old_s, new_s;
    @(negedge clk);
    en = en_v; x = x_v; ld_valid = lv; ld_ch = lc; ld_state = ls; clr = cl;
    e.tag = tag;
    for (int i = 0; i < NCH; i++) begin
      old_s = m_state[i];
      new_s = old_s;
      if (lv && (int'(lc) == i)) begin
        new_s = ls;
      end else if (en_v[i]) begin
        if (old_s > 3'b100) m_err[i] = 1'b1;
        new_s = ref_next(old_s, x_v[i]);
      end
      if (ref_z(new_s) && !ref_z(old_s)) begin
        if (m_cnt[i] < 255) m_cnt[i]++;
        if (m_cnt_s[i] < 3) m_cnt_s[i]++;
      end
      if (cl) begin
        m_cnt[i] = 0; m_cnt_s[i] = 0; m_err[i] = 1'b0;
      end
      m_state[i] = new_s;
      e.state[3*i +: 3]   = new_s;
      e.z[i]              = ref_z(new_s);
      e.cnt[8*i +: 8]     = 8'(m_cnt[i]);
      e.cnt_sat[2*i +: 2] = 2'(m_cnt_s[i]);
      e.err[i]            = m_err[i];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput({tag, " sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, " state"},     64'(state_o),   64'(e.state));
      checkOutput({e.tag, " z"},         64'(z),         64'(e.z));
      checkOutput({e.tag, " z_cnt"},     64'(z_cnt),     64'(e.cnt));
      checkOutput({e.tag, " err"},       64'(err),       64'(e.err));
      checkOutput({e.tag, " sat_state"}, 64'(state_o_s), 64'(e.state));
      checkOutput({e.tag, " sat_z"},     64'(z_s),       64'(e.z));
      checkOutput({e.tag, " sat_cnt"},   64'(z_cnt_s),   64'(e.cnt_sat));
      checkOutput({e.tag, " sat_err"},   64'(err_s),     64'(e.err));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " state"}, 64'(state_o), 64'd0);
    checkOutput({tag, " z"},     64'(z),       64'd0);
    checkOutput({tag, " z_cnt"}, 64'(z_cnt),   64'd0);
    checkOutput({tag, " err"},   64'(err),     64'd0);
    checkOutput({tag, " sat_cnt"}, 64'(z_cnt_s), 64'd0);
  endtask

  logic [6:0] t1_x = 7'b1111011;

  initial begin
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    aresetn = 1'b1;

    // Walk ch0 through x = 1,1,0,1,1,1,1 (LSB first in t1_x)
    for (int k = 0; k < 7; k++) begin
      applyStimulus(6'b000001, {5'b0, t1_x[k]}, 1'b0, 3'd0, 3'd0, 1'b0,
                    $sformatf("t1_step%0d", k));
    end

    // Illegal code held while disabled, then recovered with err set
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd2, 3'b110, 1'b0, "t2_load");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'b000000, 6'b000100, 1'b0, 3'd0, 3'd0, 1'b0,
                    $sformatf("t2_hold%0d", k));
    end
    applyStimulus(6'b000100, 6'b000100, 1'b0, 3'd0, 3'd0, 1'b0, "t2_recover");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 3'd0, 3'd0, 1'b0, "t2_sticky");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 3'd0, 3'd0, 1'b1, "t2_clr");

    // ch1 loop 100->011->010->001->100 to saturate the 2-bit counter
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd1, 3'b100, 1'b0, "t3_load");
    for (int r = 0; r < 3; r++) begin
      applyStimulus(6'b000010, 6'b000000, 1'b0, 3'd0, 3'd0, 1'b0, $sformatf("t3_r%0d_a", r));
      applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b0, $sformatf("t3_r%0d_b", r));
      applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b0, $sformatf("t3_r%0d_c", r));
      applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b0, $sformatf("t3_r%0d_d", r));
    end
    applyStimulus(6'b000010, 6'b000000, 1'b0, 3'd0, 3'd0, 1'b0, "t3_c_a");
    applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b0, "t3_c_b");
    applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b0, "t3_c_c");
    applyStimulus(6'b000010, 6'b000010, 1'b0, 3'd0, 3'd0, 1'b1, "t3_clr_rise");

    // Load beats enable on the same channel; other channels step in parallel
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd1, 3'b000, 1'b0, "t4_prep");
    applyStimulus(6'b000011, 6'b000000, 1'b1, 3'd1, 3'b100, 1'b0, "t4_ld_win");
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd6, 3'b111, 1'b0, "t4_oor6");
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd7, 3'b010, 1'b0, "t4_oor7");

    // Build ch3 up to 100 with count 5, and set err on ch4
    for (int r = 0; r < 5; r++) begin
      applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd3, 3'b000, 1'b0, $sformatf("t5_lo%0d", r));
      applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd3, 3'b100, 1'b0, $sformatf("t5_hi%0d", r));
    end
    applyStimulus(6'b000000, 6'b000000, 1'b1, 3'd4, 3'b111, 1'b0, "t5_ill");
    applyStimulus(6'b010000, 6'b000000, 1'b0, 3'd0, 3'd0, 1'b0, "t5_err");

    @(negedge clk);
    en = '0; x = '0; ld_valid = 1'b0; clr = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    checkAllZero("t5_async");
    modelReset();
    @(posedge clk);
    #1;
    checkAllZero("t5_held");
    @(negedge clk);
    aresetn = 1'b1;
    applyStimulus(6'b001000, 6'b001000, 1'b0, 3'd0, 3'd0, 1'b0, "t5_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_q3c_bank.md
Name: fsm_q3c_bank

Overview:
Bank of NUM_CH independent, fully registered copies of the team's 5-state q3c Moore machine: 3-bit state, 1-bit input x, output z.
Adds per-channel enable, a state-load port for init/test, illegal-state recovery with a sticky error flag, and a saturating counter of z rising edges.
Sits between the serial-input front end and the status register file; status readout is free-running.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 8, width of each per-channel z-rise counter (2..16)
CH_W, $clog2(NUM_CH) with minimum 1 (derived localparam), width of ld_ch

Ports:
clk  in  1  rising-edge clock
aresetn  in  1  asynchronous active-low reset
en  in  NUM_CH  per-channel step enable
x  in  NUM_CH  per-channel FSM input, sampled only when en[i]=1
ld_valid  in  1  load strobe
ld_ch  in  CH_W  channel to load
ld_state  in  3  state value to load; any code is accepted, including illegal codes
clr  in  1  synchronous clear of all counters and error flags
state_o  out  3*NUM_CH  registered state; channel i occupies bits [3i+2:3i]
z  out  NUM_CH  Moore output, decoded from the registered state
z_cnt  out  CNT_W*NUM_CH  saturating z-rise count per channel
err  out  NUM_CH  sticky illegal-state flag

Behaviour:
- Async reset (aresetn=0): all states = 000, z=0, z_cnt=0, err=0. Release is synchronous to clk.
- Legal states are 000..100. Next state when en[i]=1, given as current state: x=0 / x=1:
  - 000: 000 / 001
  - 001: 001 / 100
  - 010: 010 / 001
  - 011: 001 / 010
  - 100: 011 / 100
- Illegal states 101, 110, 111:
  - With en[i]=1, next state = 000 regardless of x, and err[i] sets on that same edge.
  - With en[i]=0, the illegal state holds and err[i] does not set.
- en[i]=0: the state holds and x[i] is ignored.
- z[i] = 1 iff state_o[i] is 011 or 100. Illegal states give z=0. z is purely combinational from the state register: zero cycles after the state update, with no x-to-z path.
- Load: ld_valid=1 with ld_ch=k < NUM_CH writes ld_state into channel k on the next edge.
  - The load overrides en[k] for that cycle.
  - The load does not set err and does not clear it.
  - ld_ch >= NUM_CH is ignored (no channel changes).
- z-rise counter:
  - Increments on an edge where z[i] goes 0 to 1, i.e. the new state is in {011,100} and the old state is not. This applies to both stepped and loaded updates.
  - Moves between 011 and 100 are not rises.
  - Saturates at 2^CNT_W-1 with no wrap.
- clr=1: on the next edge all z_cnt and err go to 0. clr wins over a simultaneous increment or err set. clr does not affect state.
- Channels are fully independent. Simultaneous load of channel k and en on other channels is allowed.
- Assertion of aresetn mid-operation takes effect immediately, regardless of clock.

Decomposition:
- Package fsm_q3c_pkg:
  - state_t, a 3-bit enum S0=000 .. S4=100.
  - function q3c_next(state_t s, logic x) returning the table above, with illegal codes mapped to S0.
  - function q3c_z(state_t s).
  - function q3c_legal(state_t s).
- Sub-module fsm_q3c_chan: one channel holding the state register, err flag and saturating counter.
  - The bank instantiates it with a generate loop and does load decode plus output packing.

Test Plan:
1. Reset, then ch0 en=1 with x = 1,1,0,1,1,1,1 → ch0 states 001,100,011,010,001,100,100. z0 = 0,1,1,0,0,1,1. z_cnt0 ends at 2. Other channels stay 000 with count 0.
2. Load ch2 with 110 and hold en2=0 for 3 cycles → state_o2=110, z2=0, err2=0. Then en2=1 with x=1 → state 000 and err2=1. err2 stays 1 until clr is pulsed, then 0.
3. CNT_W=2: drive ch1 100→011→010→001→100 repeatedly via x → count saturates at 3 after the third rise and stays at 3. clr in the same cycle as a rise → count 0.
4. Same cycle: ld_valid with ld_ch=1, ld_state=100, plus en1=1, x1=0 from 000 → state 100 (load wins) and z_cnt1 increments by 1. Also ld_ch=NUM_CH → no change on any channel.
5. Assert aresetn low between clock edges while ch3 is in 100 with count 5 → immediate state 000, z=0, count 0, err 0. First edge after release with en3=1, x=1 → 001.
